// File: rtl/sap_control_sequencer.sv
// SAP-1 style control sequencer: fetch/decode/execute with T1..T6 ring counter, PC, IR and flags.
// Optional SAP_EARLY_END_EN: ring counter restarts right after an instruction's last active T-state.
module sap_control_sequencer #(
   parameter int         PC_WIDTH   = 4,
   parameter logic [3:0] HLT_OPCODE = 4'hF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic [7:0]          bus_in,
   input  logic                cf,
   input  logic                zf,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] operand,
   output logic                ep,
   output logic                cp,
   output logic                ei,
   output logic                jp,
   output logic                ea,
   output logic                eb,
   output logic                eu,
   output logic                sub,
   output logic                nlm,
   output logic                nce,
   output logic                nli,
   output logic                nla,
   output logic                nlb,
   output logic                nlo,
   output logic [5:0]          tstate,
   output logic                halted
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   state_t              r_state;
   logic [5:0]          r_t;
   logic [PC_WIDTH-1:0] r_pc;
   logic [7:0]          r_ir;
   logic                r_cf;
   logic                r_zf;

   logic [3:0] w_op;
   logic       w_hlt, w_lda, w_add, w_sub, w_out, w_jmp, w_jc, w_jz;
   logic       w_alu, w_jump, w_last;

   assign w_op  = r_ir[7:4];
   // HLT decode has priority so a remapped HLT_OPCODE never also executes as another op.
   assign w_hlt = (w_op == HLT_OPCODE);
   assign w_lda = (w_op == 4'h0) && !w_hlt;
   assign w_add = (w_op == 4'h1) && !w_hlt;
   assign w_sub = (w_op == 4'h2) && !w_hlt;
   assign w_out = (w_op == 4'h3) && !w_hlt;
   assign w_jmp = (w_op == 4'h4) && !w_hlt;
   assign w_jc  = (w_op == 4'h5) && !w_hlt;
   assign w_jz  = (w_op == 4'h6) && !w_hlt;
   assign w_alu = w_add | w_sub;

   assign w_jump = r_t[3] & (w_jmp | (w_jc & r_cf) | (w_jz & r_zf));

`ifdef SAP_EARLY_END_EN
   assign w_last = r_t[5] | (r_t[4] & w_lda) | (r_t[3] & ~w_lda & ~w_alu);
`else
   assign w_last = r_t[5];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_t     <= 6'b0;
         r_pc    <= '0;
         r_ir    <= 8'h00;
         r_cf    <= 1'b0;
         r_zf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state <= S_RUN;
                  r_t     <= 6'b000001;
               end
            end
            S_RUN: begin
               if (r_t[1]) r_pc <= r_pc + 1'b1;
               if (r_t[2]) r_ir <= bus_in;
               if (w_jump) r_pc <= bus_in[PC_WIDTH-1:0];
               if (r_t[5] & w_alu) begin
                  r_cf <= cf;
                  r_zf <= zf;
               end
               // run is only honoured at an instruction boundary.
               if (r_t[3] & w_hlt) begin
                  r_state <= S_HALT;
                  r_t     <= 6'b0;
               end else if (w_last) begin
                  if (run) begin
                     r_t <= 6'b000001;
                  end else begin
                     r_state <= S_IDLE;
                     r_t     <= 6'b0;
                  end
               end else begin
                  r_t <= {r_t[4:0], 1'b0};
               end
            end
            S_HALT: begin
               r_t <= 6'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_t     <= 6'b0;
            end
         endcase
      end
   end

   assign pc      = r_pc;
   assign operand = r_ir[PC_WIDTH-1:0];
   assign tstate  = r_t;
   assign halted  = (r_state == S_HALT);

   assign ep  = r_t[0];
   assign cp  = r_t[1];
   assign ei  = (r_t[3] & (w_lda | w_alu)) | w_jump;
   assign jp  = w_jump;
   assign ea  = r_t[3] & w_out;
   assign eb  = 1'b0;
   assign eu  = r_t[5] & w_alu;
   assign sub = (r_t[4] | r_t[5]) & w_sub;
   assign nlm = ~(r_t[0] | (r_t[3] & (w_lda | w_alu)));
   assign nce = ~(r_t[2] | (r_t[4] & (w_lda | w_alu)));
   assign nli = ~r_t[2];
   assign nla = ~((r_t[4] & w_lda) | (r_t[5] & w_alu));
   assign nlb = ~(r_t[4] & w_alu);
   assign nlo = ~(r_t[3] & w_out);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed program run against sap_control_sequencer with a small RAM/bus model;
// expectations are queued per cycle and compared by an independent negedge monitor.
module tb_sap_control_sequencer;

   // control word order: {ep,cp,ei,jp, ea,eb,eu,sub, nlm,nce,nli,nla,nlb,nlo}
   localparam logic [13:0] C_IDLE = 14'b0000_0000_111111;
   localparam logic [13:0] C_T1   = 14'b1000_0000_011111;
   localparam logic [13:0] C_T2   = 14'b0100_0000_111111;
   localparam logic [13:0] C_T3   = 14'b0000_0000_100111;
   localparam logic [13:0] C_MA   = 14'b0010_0000_011111;
   localparam logic [13:0] C_LDA5 = 14'b0000_0000_101011;
   localparam logic [13:0] C_ADD5 = 14'b0000_0000_101101;
   localparam logic [13:0] C_SUB5 = 14'b0000_0001_101101;
   localparam logic [13:0] C_ADD6 = 14'b0000_0010_111011;
   localparam logic [13:0] C_SUB6 = 14'b0000_0011_111011;
   localparam logic [13:0] C_OUT  = 14'b0000_1000_111110;
   localparam logic [13:0] C_JMP  = 14'b0011_0000_111111;

   localparam logic [28:0] M_PC  = 29'h1E00_0000;
   localparam logic [28:0] M_OP  = 29'h01E0_0000;
   localparam logic [28:0] M_CTL = 29'h001F_FF80;
   localparam logic [28:0] M_TS  = 29'h0000_007F;
   localparam logic [28:0] M_ALL = 29'h1FFF_FFFF;

`ifdef SAP_EARLY_END_EN
   localparam int LEN_LDA   = 5;
   localparam int LEN_SHORT = 4;
`else
   localparam int LEN_LDA   = 6;
   localparam int LEN_SHORT = 6;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       cf = 1'b0;
   logic       zf = 1'b0;
   logic [7:0] bus_in;
   logic [3:0] pc, operand;
   logic       ep, cp, ei, jp, ea, eb, eu, sub, nlm, nce, nli, nla, nlb, nlo;
   logic [5:0] tstate;
   logic       halted;

   sap_control_sequencer #(.PC_WIDTH(4), .HLT_OPCODE(4'hF)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .bus_in(bus_in), .cf(cf), .zf(zf),
      .pc(pc), .operand(operand),
      .ep(ep), .cp(cp), .ei(ei), .jp(jp), .ea(ea), .eb(eb), .eu(eu), .sub(sub),
      .nlm(nlm), .nce(nce), .nli(nli), .nla(nla), .nlb(nlb), .nlo(nlo),
      .tstate(tstate), .halted(halted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Top-level bus model: PC, IR operand or RAM[MAR] onto the bus.
   logic [7:0] ram [16];
   logic [3:0] mar = 4'h0;
   assign bus_in = ep ? {4'h0, pc} : ei ? {4'h0, operand} : !nce ? ram[mar] : 8'h00;
   always @(posedge clk) if (!nlm) mar <= bus_in[3:0];

   logic [28:0] obs;
   assign obs = {pc, operand, ep, cp, ei, jp, ea, eb, eu, sub,
                 nlm, nce, nli, nla, nlb, nlo, tstate, halted};

   int          q_cyc [$];
   logic [28:0] q_val [$];
   logic [28:0] q_msk [$];
   string       q_nm  [$];
   int checks = 0;
   int failures = 0;

   task automatic push(input string nm, input int c, input logic [28:0] v, input logic [28:0] m);
      q_cyc.push_back(c);
      q_val.push_back(v);
      q_msk.push_back(m);
      q_nm.push_back(nm);
   endtask

   task automatic e_ctl(input string nm, input int c, input logic [13:0] ctl);
      push(nm, c, {8'h00, ctl, 7'h00}, M_CTL);
   endtask
   task automatic e_ts(input string nm, input int c, input logic [5:0] ts, input logic h);
      push(nm, c, {22'h0, ts, h}, M_TS);
   endtask
   task automatic e_pc(input string nm, input int c, input logic [3:0] p);
      push(nm, c, {p, 25'h0}, M_PC);
   endtask
   task automatic e_op(input string nm, input int c, input logic [3:0] o);
      push(nm, c, {4'h0, o, 21'h0}, M_OP);
   endtask
   task automatic e_rst(input string nm, input int c);
      push(nm, c, {8'h00, C_IDLE, 7'h00}, M_ALL);
   endtask

   task automatic exp_instr(input string nm, input int s, input logic [3:0] p, input logic [7:0] ir,
                            input int len, input logic [13:0] c4, input logic [13:0] c5,
                            input logic [13:0] c6);
      e_ts ({nm, ".t1.ts"},  s,     6'b000001, 1'b0);
      e_ctl({nm, ".t1.ctl"}, s,     C_T1);
      e_pc ({nm, ".t1.pc"},  s,     p);
      e_ts ({nm, ".t2.ts"},  s + 1, 6'b000010, 1'b0);
      e_ctl({nm, ".t2.ctl"}, s + 1, C_T2);
      e_ts ({nm, ".t3.ts"},  s + 2, 6'b000100, 1'b0);
      e_ctl({nm, ".t3.ctl"}, s + 2, C_T3);
      e_pc ({nm, ".t3.pc"},  s + 2, p + 4'd1);
      e_ts ({nm, ".t4.ts"},  s + 3, 6'b001000, 1'b0);
      e_ctl({nm, ".t4.ctl"}, s + 3, c4);
      e_op ({nm, ".t4.op"},  s + 3, ir[3:0]);
      if (len >= 5) begin
         e_ts ({nm, ".t5.ts"},  s + 4, 6'b010000, 1'b0);
         e_ctl({nm, ".t5.ctl"}, s + 4, c5);
      end
      if (len >= 6) begin
         e_ts ({nm, ".t6.ts"},  s + 5, 6'b100000, 1'b0);
         e_ctl({nm, ".t6.ctl"}, s + 5, c6);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   string       m_nm;
   logic [28:0] m_v, m_m;
   int          m_c;
   always @(negedge clk) begin
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         m_c  = q_cyc.pop_front();
         m_v  = q_val.pop_front();
         m_m  = q_msk.pop_front();
         m_nm = q_nm.pop_front();
         checks++;
         if (m_c != cyc || ((obs ^ m_v) & m_m) != 29'h0) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h required=%h mask=%h", m_nm, m_c, obs & m_m, m_v & m_m, m_m);
         end
      end
   end

   initial begin
      int c, s, s_lda, s_sub, s_h, s2;
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      ram[0]  = 8'h05;  ram[1]  = 8'h16;  ram[2]  = 8'h59;  ram[9]  = 8'h63;
      ram[10] = 8'h30;  ram[11] = 8'h27;  ram[12] = 8'h6F;  ram[15] = 8'h80;
      cf = 1'b1;
      zf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      c = cyc;
      e_rst("reset", c);
      rst_n = 1'b1;
      run   = 1'b1;

      s = c + 1;
      s_lda = s;
      exp_instr("lda",   s, 4'd0,  8'h05, LEN_LDA,   C_MA,   C_LDA5, C_IDLE); s += LEN_LDA;
      exp_instr("add",   s, 4'd1,  8'h16, 6,         C_MA,   C_ADD5, C_ADD6); s += 6;
      exp_instr("jc_t",  s, 4'd2,  8'h59, LEN_SHORT, C_JMP,  C_IDLE, C_IDLE); s += LEN_SHORT;
      exp_instr("jz_nt", s, 4'd9,  8'h63, LEN_SHORT, C_IDLE, C_IDLE, C_IDLE); s += LEN_SHORT;
      exp_instr("out",   s, 4'd10, 8'h30, LEN_SHORT, C_OUT,  C_IDLE, C_IDLE); s += LEN_SHORT;
      s_sub = s;
      exp_instr("sub",   s, 4'd11, 8'h27, 6,         C_MA,   C_SUB5, C_SUB6); s += 6;
      exp_instr("jz_t",  s, 4'd12, 8'h6F, LEN_SHORT, C_JMP,  C_IDLE, C_IDLE); s += LEN_SHORT;
      exp_instr("nop",   s, 4'd15, 8'h80, LEN_SHORT, C_IDLE, C_IDLE, C_IDLE); s += LEN_SHORT;
      s_h = s;
      exp_instr("hlt",   s, 4'd0,  8'hF0, 4,         C_IDLE, C_IDLE, C_IDLE);
      e_ts ("halt.ts",  s_h + 4, 6'b000000, 1'b1);
      e_ctl("halt.ctl", s_h + 4, C_IDLE);
      e_pc ("halt.pc",  s_h + 4, 4'd1);
      e_ts ("halt_run.ts", s_h + 9, 6'b000000, 1'b1);
      e_pc ("halt_run.pc", s_h + 9, 4'd1);

      wait_cyc(s_lda + 4);
      ram[0] = 8'hF0;
      wait_cyc(s_sub);
      cf = 1'b0;
      zf = 1'b1;
      wait_cyc(s_h + 5); run = 1'b0;
      wait_cyc(s_h + 6); run = 1'b1;
      wait_cyc(s_h + 7); run = 1'b0;
      wait_cyc(s_h + 8); run = 1'b1;

      // Reset out of HALT, then reset again in the middle of ADD's T5.
      wait_cyc(s_h + 10);
      run    = 1'b0;
      rst_n  = 1'b0;
      ram[0] = 8'h16;
      e_rst("rst_halt", cyc);
      c = cyc;
      wait_cyc(c + 1);
      rst_n = 1'b1;
      run   = 1'b1;
      s = c + 2;
      exp_instr("add_r", s, 4'd0, 8'h16, 5, C_MA, C_ADD5, C_IDLE);
      wait_cyc(s + 4);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      run   = 1'b0;
      wait_cyc(s + 5);
      e_rst("rst_t5",  s + 5);
      e_rst("rst_rel", s + 6);
      rst_n = 1'b1;

      // run dropped at T2: instruction completes, then IDLE until run returns.
      wait_cyc(s + 6);
      ram[0] = 8'h05;
      ram[1] = 8'h30;
      run = 1'b1;
      s = cyc + 1;
      exp_instr("lda_d", s, 4'd0, 8'h05, LEN_LDA, C_MA, C_LDA5, C_IDLE);
      e_ts ("idle1.ts",  s + LEN_LDA,     6'b000000, 1'b0);
      e_ctl("idle1.ctl", s + LEN_LDA,     C_IDLE);
      e_pc ("idle1.pc",  s + LEN_LDA,     4'd1);
      e_ts ("idle2.ts",  s + LEN_LDA + 1, 6'b000000, 1'b0);
      wait_cyc(s + 1);
      run = 1'b0;
      wait_cyc(s + LEN_LDA + 1);
      run = 1'b1;
      s2 = s + LEN_LDA + 2;
      exp_instr("out_r", s2, 4'd1, 8'h30, LEN_SHORT, C_OUT, C_IDLE, C_IDLE);
      e_ts("idle3.ts", s2 + LEN_SHORT, 6'b000000, 1'b0);
      e_pc("idle3.pc", s2 + LEN_SHORT, 4'd2);
      wait_cyc(s2 + 1);
      run = 1'b0;

      for (int i = 0; i < 50 && q_cyc.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (q_cyc.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q_cyc.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
